// File: rtl/rgb_mem_sequencer_if.sv
// Request, bank-port and response signals of the RGB memory sequencer.
// The sequencer uses the master modport; the pipeline/bank side uses slave.
interface rgb_mem_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_rgb;
    logic [ADDR_W-1:0] req_addr;
    logic [23:0]       req_wdata;
    logic              stall;
    logic              mem_en;
    logic              mem_we;
    logic [1:0]        mem_bank;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              rsp_valid;
    logic [23:0]       rsp_rdata;

    modport master (
        input  req_valid, req_we, req_rgb, req_addr, req_wdata, mem_rdata,
        output stall, mem_en, mem_we, mem_bank, mem_addr, mem_wdata, rsp_valid, rsp_rdata
    );

    modport slave (
        output req_valid, req_we, req_rgb, req_addr, req_wdata, mem_rdata,
        input  stall, mem_en, mem_we, mem_bank, mem_addr, mem_wdata, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/rgb_mem_sequencer.sv
// Serialises RGB load/store instructions onto a shared 8-bit bank port, stalling the pipeline meanwhile.
// Define RGB_SEQ_ABORT_EN to add the abort input that cancels an access in flight.
//
//   state | meaning
//   IDLE  | waiting for req_valid; request latched on acceptance
//   ISSUE | one bank strobe for the current channel
//   WAIT  | MEM_LAT cycles for read data, captured on the last one
//   DONE  | rsp_valid pulse, pipeline released
module rgb_mem_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
`ifdef RGB_SEQ_ABORT_EN
    input  logic abort,
`endif
    rgb_mem_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t            state, state_nx;
    logic              we_q;
    logic [1:0]        rgb_q;
    logic [1:0]        chan_q;
    logic [ADDR_W-1:0] addr_q;
    logic [23:0]       wdata_q;
    logic [23:0]       asm_q;
    logic [23:0]       rsp_q;
    logic [2:0]        cnt_q;

    logic              abort_in;
    logic              busy;
    logic              abort_now;
    logic              last_chan;
    logic              wait_tc;
    logic              issue_go;
    logic [7:0]        issue_byte;
    logic [23:0]       rd_asm;

`ifdef RGB_SEQ_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    assign busy      = (state == ISSUE) || (state == WAIT);
    assign abort_now = abort_in && busy;
    assign last_chan = (rgb_q != 2'b11) || (chan_q == 2'd2);
    assign wait_tc   = (cnt_q == 3'd0);
    assign issue_go  = (state == ISSUE) && !rst && !abort_now;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nx = ISSUE;
            ISSUE:   state_nx = we_q ? (last_chan ? DONE : ISSUE) : WAIT;
            WAIT:    if (wait_tc) state_nx = last_chan ? DONE : ISSUE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort_now) state_nx = IDLE;
    end

    // Lane placement: all-colour accesses use the channel's byte, single-colour uses [7:0].
    always_comb begin
        issue_byte = wdata_q[7:0];
        rd_asm     = asm_q;
        if (rgb_q == 2'b11) begin
            case (chan_q)
                2'd0:    begin issue_byte = wdata_q[23:16]; rd_asm[23:16] = bus.mem_rdata; end
                2'd1:    begin issue_byte = wdata_q[15:8];  rd_asm[15:8]  = bus.mem_rdata; end
                default: begin issue_byte = wdata_q[7:0];   rd_asm[7:0]   = bus.mem_rdata; end
            endcase
        end else begin
            rd_asm[7:0] = bus.mem_rdata;
        end
    end

    always_comb begin
        bus.mem_en    = issue_go;
        bus.mem_we    = issue_go && we_q;
        bus.mem_bank  = 2'd0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 8'd0;
        if (issue_go) begin
            bus.mem_bank = chan_q;
            bus.mem_addr = addr_q;
            if (we_q) bus.mem_wdata = issue_byte;
        end
        bus.stall     = !rst && ((state == IDLE) ? bus.req_valid : busy);
        bus.rsp_valid = !rst && (state == DONE);
        bus.rsp_rdata = rsp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            rgb_q   <= 2'd0;
            chan_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 24'd0;
            asm_q   <= 24'd0;
            rsp_q   <= 24'd0;
            cnt_q   <= 3'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        rgb_q   <= bus.req_rgb;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        asm_q   <= 24'd0;
                        chan_q  <= (bus.req_rgb == 2'b11) ? 2'd0 : bus.req_rgb;
                    end
                end
                ISSUE: begin
                    if (!abort_now) begin
                        if (!we_q) begin
                            cnt_q <= LAT_M1;
                        end else if (last_chan) begin
                            rsp_q <= 24'd0;
                        end else begin
                            chan_q <= chan_q + 2'd1;
                        end
                    end
                end
                WAIT: begin
                    if (!abort_now) begin
                        if (!wait_tc) begin
                            cnt_q <= cnt_q - 3'd1;
                        end else begin
                            asm_q <= rd_asm;
                            if (last_chan) rsp_q <= rd_asm;
                            else           chan_q <= chan_q + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb_mem_sequencer.sv
// Self-checking bench: two sequencers (MEM_LAT 1 and 3) share one random request stream,
// each checked every cycle against a per-request cycle schedule built from the access rules.
`timescale 1ns/1ps
module tb_rgb_mem_sequencer;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct {
        bit        first;
        bit        done;
        bit        stall;
        bit        en;
        bit        we;
        bit [1:0]  bank;
        bit [15:0] addr;
        bit [7:0]  wdata;
        bit [23:0] rdata;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ab;
    logic        r_valid, r_we;
    logic [1:0]  r_rgb;
    logic [15:0] r_addr;
    logic [23:0] r_wdata;

    rgb_mem_sequencer_if #(.ADDR_W(16)) bus1 ();
    rgb_mem_sequencer_if #(.ADDR_W(16)) bus3 ();

    rgb_mem_sequencer #(.ADDR_W(16), .MEM_LAT(LAT0)) dut1 (
        .clk(clk),
        .rst(rst),
`ifdef RGB_SEQ_ABORT_EN
        .abort(ab),
`endif
        .bus(bus1)
    );

    rgb_mem_sequencer #(.ADDR_W(16), .MEM_LAT(LAT1)) dut3 (
        .clk(clk),
        .rst(rst),
`ifdef RGB_SEQ_ABORT_EN
        .abort(ab),
`endif
        .bus(bus3)
    );

    rec_t      q0[$];
    rec_t      q1[$];
    bit [7:0]  bmem [2][3][256];
    bit [7:0]  mmem [2][3][256];
    bit [7:0]  pend_d [2][8];
    bit        pend_v [2][8];
    bit [23:0] exp_rsp [2];
    int        cyc;
    int        checks;
    int        errors;
    int        en_cnt [2];
    int        rsp_cnt [2];
    int        first_en_cyc [2];
    int        last_en_cyc [2];
    int        last_rsp_cyc [2];
    bit [23:0] last_rsp_data [2];
    bit [1:0]  last_bank [2];
    bit [7:0]  last_wdata [2];
    bit [15:0] last_addr [2];

    function automatic int lat_of(input bit l);
        return l ? LAT1 : LAT0;
    endfunction

    task automatic chk(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d cyc %0d: got %0h expected %0h", name, l, cyc, act, exp);
        end
    endtask

    task automatic push(input bit l, input rec_t r);
        if (l) q1.push_back(r); else q0.push_back(r);
    endtask

    function automatic int qsize(input bit l);
        return l ? q1.size() : q0.size();
    endfunction

    task automatic pop(input bit l, output rec_t r);
        if (l) r = q1.pop_front(); else r = q0.pop_front();
    endtask

    task automatic qclear(input bit l);
        if (l) q1.delete(); else q0.delete();
    endtask

    // Expected cycle-by-cycle behaviour of one accepted request, starting at the acceptance cycle.
    task automatic build(input bit l);
        rec_t      r;
        bit [1:0]  ch;
        bit [23:0] rd;
        int        nch;
        rd  = 24'd0;
        nch = (r_rgb == 2'b11) ? 3 : 1;
        r = '{default: 0};
        r.first = 1'b1;
        r.stall = 1'b1;
        push(l, r);
        for (int k = 0; k < nch; k++) begin
            ch = (r_rgb == 2'b11) ? 2'(k) : r_rgb;
            r = '{default: 0};
            r.stall = 1'b1;
            r.en    = 1'b1;
            r.we    = r_we;
            r.bank  = ch;
            r.addr  = r_addr;
            if (r_we) r.wdata = (r_rgb == 2'b11) ? r_wdata[8*(2-k) +: 8] : r_wdata[7:0];
            push(l, r);
            if (!r_we) begin
                if (r_rgb == 2'b11) rd[8*(2-k) +: 8] = mmem[l][ch][r_addr[7:0]];
                else                rd[7:0]          = mmem[l][ch][r_addr[7:0]];
                r = '{default: 0};
                r.stall = 1'b1;
                for (int w = 0; w < lat_of(l); w++) push(l, r);
            end
        end
        r = '{default: 0};
        r.done  = 1'b1;
        r.rdata = rd;
        push(l, r);
    endtask

    task automatic sample(input bit l, output logic st, output logic en, output logic we, output logic rv,
                          output logic [1:0] bk, output logic [15:0] ad, output logic [7:0] wd,
                          output logic [23:0] rd);
        if (l) begin
            st = bus3.stall; en = bus3.mem_en; we = bus3.mem_we; rv = bus3.rsp_valid;
            bk = bus3.mem_bank; ad = bus3.mem_addr; wd = bus3.mem_wdata; rd = bus3.rsp_rdata;
        end else begin
            st = bus1.stall; en = bus1.mem_en; we = bus1.mem_we; rv = bus1.rsp_valid;
            bk = bus1.mem_bank; ad = bus1.mem_addr; wd = bus1.mem_wdata; rd = bus1.rsp_rdata;
        end
    endtask

    task automatic step(input bit l);
        rec_t        r;
        logic        a_st, a_en, a_we, a_rv;
        logic [1:0]  a_bk;
        logic [15:0] a_ad;
        logic [7:0]  a_wd;
        logic [23:0] a_rd;
        bit          aborted;
        bit [2:0]    slot;
        int          li;
        li = int'(l);
        sample(l, a_st, a_en, a_we, a_rv, a_bk, a_ad, a_wd, a_rd);

        // Bank model and bookkeeping react to what the DUT actually did.
        if (a_en === 1'b1) begin
            en_cnt[l]++;
            if (first_en_cyc[l] < 0) first_en_cyc[l] = cyc;
            last_en_cyc[l] = cyc;
            last_bank[l]   = a_bk;
            last_wdata[l]  = a_wd;
            last_addr[l]   = a_ad;
            if (a_bk < 2'd3) begin
                if (a_we === 1'b1) begin
                    bmem[l][a_bk][a_ad[7:0]] = a_wd;
                end else begin
                    slot = 3'(cyc + lat_of(l));
                    pend_d[l][slot] = bmem[l][a_bk][a_ad[7:0]];
                    pend_v[l][slot] = 1'b1;
                end
            end
        end
        if (a_rv === 1'b1) begin
            rsp_cnt[l]++;
            last_rsp_cyc[l]  = cyc;
            last_rsp_data[l] = a_rd;
        end

        if (rst) begin
            chk("stall_in_reset", li, 32'(a_st), 32'd0);
            chk("mem_en_in_reset", li, 32'(a_en), 32'd0);
            chk("rsp_valid_in_reset", li, 32'(a_rv), 32'd0);
            qclear(l);
            exp_rsp[l] = 24'd0;
            return;
        end

        if (qsize(l) == 0 && r_valid) build(l);
        if (qsize(l) == 0) r = '{default: 0};
        else               pop(l, r);

        aborted = ab && r.stall && !r.first;
        if (r.done) exp_rsp[l] = r.rdata;

        chk("stall", li, 32'(a_st), 32'(r.stall));
        chk("mem_en", li, 32'(a_en), 32'(r.en && !aborted));
        if (r.en && !aborted) begin
            chk("mem_we", li, 32'(a_we), 32'(r.we));
            chk("mem_bank", li, 32'(a_bk), 32'(r.bank));
            chk("mem_addr", li, 32'(a_ad), 32'(r.addr));
            chk("mem_wdata", li, 32'(a_wd), 32'(r.wdata));
            if (r.we) mmem[l][r.bank][r.addr[7:0]] = r.wdata;
        end
        chk("rsp_valid", li, 32'(a_rv), 32'(r.done));
        chk("rsp_rdata", li, 32'(a_rd), 32'(exp_rsp[l]));
        if (aborted) qclear(l);
    endtask

    task automatic tick();
        bit [2:0] slot;
        @(negedge clk);
        step(1'b0);
        step(1'b1);
        @(posedge clk);
        #1;
        cyc++;
        slot = 3'(cyc);
        for (int l = 0; l < 2; l++) begin
            logic [7:0] v;
            if (pend_v[l][slot]) begin
                v = pend_d[l][slot];
                pend_v[l][slot] = 1'b0;
            end else begin
                v = 8'($urandom);
            end
            if (l == 1) bus3.mem_rdata = v; else bus1.mem_rdata = v;
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [1:0] rgb, input logic [15:0] addr,
                         input logic [23:0] wd);
        r_valid = v; r_we = we; r_rgb = rgb; r_addr = addr; r_wdata = wd;
        bus1.req_valid = v; bus1.req_we = we; bus1.req_rgb = rgb; bus1.req_addr = addr; bus1.req_wdata = wd;
        bus3.req_valid = v; bus3.req_we = we; bus3.req_rgb = rgb; bus3.req_addr = addr; bus3.req_wdata = wd;
    endtask

    task automatic clear_log();
        for (int l = 0; l < 2; l++) begin
            en_cnt[l] = 0; rsp_cnt[l] = 0; first_en_cyc[l] = -1; last_en_cyc[l] = -1; last_rsp_cyc[l] = -1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int c0;

    initial begin
        checks = 0; errors = 0; cyc = 0;
        for (int l = 0; l < 2; l++)
            for (int b = 0; b < 3; b++)
                for (int i = 0; i < 256; i++) begin
                    bmem[l][b][i] = 8'((b * 53 + i * 7 + 3) ^ 8'h5A);
                    mmem[l][b][i] = 8'((b * 53 + i * 7 + 3) ^ 8'h5A);
                end
        for (int l = 0; l < 2; l++)
            for (int s = 0; s < 8; s++) pend_v[l][s] = 1'b0;
        bus1.mem_rdata = 8'h00;
        bus3.mem_rdata = 8'h00;
        ab  = 1'b0;
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b11, 16'h0040, 24'h0);
        clear_log();
        ticks(2);
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 16'h0, 24'h0);
        ticks(2);
        for (int l = 0; l < 2; l++) begin
            chk("reset_no_strobe", l, 32'(en_cnt[l]), 32'd0);
            chk("reset_rsp_rdata", l, 32'(l ? bus3.rsp_rdata : bus1.rsp_rdata), 32'd0);
        end

        // Single-colour store of G.
        clear_log();
        c0 = cyc;
        drive(1'b1, 1'b1, 2'b01, 16'h0123, 24'h00AA55);
        tick();
        drive(1'b0, 1'b0, 2'b00, 16'h0, 24'h0);
        ticks(5);
        for (int l = 0; l < 2; l++) begin
            chk("ss_strobes", l, 32'(en_cnt[l]), 32'd1);
            chk("ss_strobe_cycle", l, 32'(first_en_cyc[l] - c0), 32'd1);
            chk("ss_bank", l, 32'(last_bank[l]), 32'd1);
            chk("ss_wdata", l, 32'(last_wdata[l]), 32'h55);
            chk("ss_addr", l, 32'(last_addr[l]), 32'h0123);
            chk("ss_rsp_cycle", l, 32'(last_rsp_cyc[l] - c0), 32'd2);
        end

        // All-colour load with bytes 11/22/33.
        for (int l = 0; l < 2; l++) begin
            bmem[l][0][8'h40] = 8'h11; bmem[l][1][8'h40] = 8'h22; bmem[l][2][8'h40] = 8'h33;
            mmem[l][0][8'h40] = 8'h11; mmem[l][1][8'h40] = 8'h22; mmem[l][2][8'h40] = 8'h33;
        end
        clear_log();
        c0 = cyc;
        drive(1'b1, 1'b0, 2'b11, 16'h0040, 24'hFFFFFF);
        tick();
        drive(1'b0, 1'b0, 2'b00, 16'h0, 24'h0);
        ticks(16);
        for (int l = 0; l < 2; l++) begin
            chk("al_strobes", l, 32'(en_cnt[l]), 32'd3);
            chk("al_first_strobe", l, 32'(first_en_cyc[l] - c0), 32'd1);
            chk("al_last_strobe", l, 32'(last_en_cyc[l] - c0), (l == 0) ? 32'd5 : 32'd9);
            chk("al_rsp_cycle", l, 32'(last_rsp_cyc[l] - c0), (l == 0) ? 32'd7 : 32'd13);
            chk("al_rsp_rdata", l, 32'(last_rsp_data[l]), 32'h112233);
        end

        // Back-to-back: all-colour store, then load of B accepted the cycle after DONE.
        clear_log();
        c0 = cyc;
        drive(1'b1, 1'b1, 2'b11, 16'h0050, 24'hA1B27E);
        ticks(5);
        drive(1'b1, 1'b0, 2'b10, 16'h0050, 24'h0);
        tick();
        drive(1'b0, 1'b0, 2'b00, 16'h0, 24'h0);
        ticks(8);
        for (int l = 0; l < 2; l++) begin
            chk("b2b_responses", l, 32'(rsp_cnt[l]), 32'd2);
            chk("b2b_load_strobe", l, 32'(last_en_cyc[l] - c0), 32'd6);
            chk("b2b_rsp_cycle", l, 32'(last_rsp_cyc[l] - c0), (l == 0) ? 32'd8 : 32'd10);
            chk("b2b_rsp_rdata", l, 32'(last_rsp_data[l]), 32'h00007E);
        end

`ifdef RGB_SEQ_ABORT_EN
        clear_log();
        c0 = cyc;
        drive(1'b1, 1'b0, 2'b11, 16'h0040, 24'h0);
        tick();
        drive(1'b0, 1'b0, 2'b00, 16'h0, 24'h0);
        ticks(5);
        ab = 1'b1;
        tick();
        ab = 1'b0;
        ticks(15);
        for (int l = 0; l < 2; l++) begin
            chk("abort_strobes", l, 32'(en_cnt[l]), (l == 0) ? 32'd3 : 32'd2);
            chk("abort_no_rsp", l, 32'(rsp_cnt[l]), 32'd0);
            chk("abort_rsp_kept", l, 32'(l ? bus3.rsp_rdata : bus1.rsp_rdata), 32'h00007E);
        end
`endif

        // Reset during the second WAIT of the MEM_LAT=3 lane.
        clear_log();
        c0 = cyc;
        drive(1'b1, 1'b0, 2'b11, 16'h0040, 24'h0);
        tick();
        drive(1'b0, 1'b0, 2'b00, 16'h0, 24'h0);
        ticks(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ticks(15);
        for (int l = 0; l < 2; l++) begin
            chk("midrst_strobes", l, 32'(en_cnt[l]), (l == 0) ? 32'd3 : 32'd2);
            chk("midrst_no_rsp", l, 32'(rsp_cnt[l]), 32'd0);
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
`ifdef RGB_SEQ_ABORT_EN
            ab = ($urandom_range(0, 39) == 0);
`endif
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  16'($urandom_range(0, 3) * 256 + $urandom_range(0, 15)), 24'($urandom));
            tick();
        end
        rst = 1'b0;
        ab  = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 16'h0, 24'h0);
        ticks(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rgb_mem_sequencer.md
Name: rgb_mem_sequencer

Overview:
- Sequences data-memory accesses for load/store instructions that carry an RGB colour select.
- Colour memory is three 8-bit banks (R, G, B) behind one shared port.
- A single-colour access takes one bank transaction; an all-colour access is serialised into three (R, then G, then B).
- The pipeline is stalled while an access runs, and one packed response is returned at the end.

Parameters:
ADDR_W, 16, width of the pixel address.
MEM_LAT, 1, read latency of the bank port in cycles; legal range 1..4.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  memory instruction present (load or store), from the control unit
req_we  in  1  1 = store, 0 = load
req_rgb  in  2  colour select: 00=R, 01=G, 10=B, 11=all three
req_addr  in  ADDR_W  pixel address
req_wdata  in  24  store data {R[23:16], G[15:8], B[7:0]}
stall  out  1  hold PC and pipeline registers
mem_en  out  1  bank port access strobe
mem_we  out  1  bank port write enable
mem_bank  out  2  bank select: 0=R, 1=G, 2=B
mem_addr  out  ADDR_W  bank port address
mem_wdata  out  8  bank port write byte
mem_rdata  in  8  bank port read byte; valid MEM_LAT cycles after a read strobe
rsp_valid  out  1  one-cycle pulse: access complete
rsp_rdata  out  24  load result

Behaviour:
- One clock domain, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - mem_en, mem_we, mem_bank, mem_addr, mem_wdata, rsp_valid, rsp_rdata all = 0.
  - stall is forced to 0 while rst = 1.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - stall = req_valid (combinational).
  - If req_valid = 1: latch we, rgb, addr and wdata; clear the read-assembly register; set channel = R for rgb 11, otherwise channel = rgb; go to ISSUE.
  - req_* inputs are ignored in every state except IDLE.
- ISSUE (one cycle):
  - mem_en = 1, mem_we = latched we, mem_bank = channel, mem_addr = latched addr.
  - mem_wdata = the channel's byte of latched wdata for an all-colour store, latched wdata[7:0] for a single-colour store, 0 for a load.
  - Store: if last channel go to DONE, otherwise advance channel and stay in ISSUE.
  - Load: go to WAIT.
- WAIT:
  - Lasts exactly MEM_LAT cycles, counted by a 3-bit counter; mem_en = 0.
  - At the end of the last WAIT cycle, capture mem_rdata into the channel's lane: R→[23:16], G→[15:8], B→[7:0] for an all-colour load; [7:0] for a single-colour load, upper bits 0.
  - Then: if last channel go to DONE, otherwise advance channel and go to ISSUE.
- DONE (one cycle):
  - rsp_valid = 1, stall = 0.
  - rsp_rdata = assembled value for a load, 0 for a store; it holds until the next DONE.
  - Next state IDLE.
- stall = 1 in ISSUE and WAIT.
- Cycle counts, request accepted at cycle 0:
  - Store: DONE at cycle 2 (single) or 4 (all).
  - Load: DONE at cycle 2+MEM_LAT (single) or 1+3·(1+MEM_LAT) (all).
- Back-to-back requests:
  - The pipeline advances during DONE.
  - The next request is seen in IDLE on the following cycle; there is no overlap between requests.
- Reset mid-operation: return to IDLE at the next edge. No rsp_valid is issued, partial read data is discarded, and no further mem_en pulses occur.
- Only one access is outstanding on the bank port at any time.

Optional Feature:
- Macro: RGB_SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort = 1 in ISSUE or WAIT forces mem_en = 0 in that cycle and returns to IDLE at the next edge.
  - No rsp_valid is issued, stall drops the cycle after abort, and rsp_rdata keeps its previous value.
  - abort is ignored in IDLE and DONE.
- Not defined: no abort port; every accepted request runs to DONE.

Test Plan:
- Reset: rst = 1 for 2 cycles with req_valid = 1 → all outputs 0, stall = 0, no mem_en.
- Single store: rgb = 01, addr = 0x0123, wdata = 0x00AA55 → one mem_en with bank = 1, we = 1, wdata = 0x55, addr = 0x0123 at cycle 1; rsp_valid at cycle 2; stall high cycles 0–1.
- All-colour load, MEM_LAT = 1: bank model returns 0x11/0x22/0x33 for R/G/B → strobes at cycles 1, 3, 5 on banks 0, 1, 2; rsp_valid at cycle 7 with rsp_rdata = 0x112233.
- All-colour load, MEM_LAT = 3: same model → rsp_valid at cycle 13, rsp_rdata = 0x112233; mem_en never high in WAIT.
- Back-to-back: all-colour store then single load of B (returns 0x7E) → second request accepted in the cycle after DONE; rsp_rdata = 0x00007E.
- Mid-operation: rst (or abort with RGB_SEQ_ABORT_EN) asserted during the second WAIT of an all-colour load → IDLE next cycle, no rsp_valid, no further mem_en, rsp_rdata unchanged.
